// File: rtl/boron_pkg.sv
// Shared constants, types and round/key-schedule functions for the BORON-64/80 core.
package boron_pkg;

    localparam int DATA_W         = 64;
    localparam int KEY_W_DEFAULT  = 80;
    localparam int ROUNDS_DEFAULT = 25;

    // Nibble i of this constant is S(i): S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}
    localparam logic [63:0] SBOX    = 64'h6358_F02D_AC97_1B4E;
    localparam int          BSHUF   [8] = '{5, 4, 7, 1, 6, 0, 3, 2};
    localparam int          ROT_AMT [4] = '{1, 4, 7, 9};

    typedef enum logic {
        IDLE,
        ROUND
    } fsm_t;

    function automatic logic [3:0] s4(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = s4(x[4*i +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] shuf64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            y[8*i +: 8] = x[8*BSHUF[i] +: 8];
        end
        return y;
    endfunction

    function automatic logic [63:0] rot64(input logic [63:0] x);
        logic [63:0] y;
        logic [15:0] w;
        logic [31:0] t;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            w = x[16*i +: 16];
            t = {w, w} << ROT_AMT[i];
            y[16*i +: 16] = t[31:16];
        end
        return y;
    endfunction

    function automatic logic [63:0] lin64(input logic [63:0] x);
        logic [15:0] w0, w1, w2, w3;
        {w3, w2, w1, w0} = x;
        return {w3 ^ w2 ^ w0, w2 ^ w0, w3 ^ w1, w3 ^ w1 ^ w0};
    endfunction

    function automatic logic [79:0] kupd80(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r         = {k[66:0], k[79:67]};
        r[3:0]    = s4(r[3:0]);
        r[63:59]  = r[63:59] ^ rc;
        return r;
    endfunction

    // Reference encryption: the last round's output is whitened with the key after its update
    function automatic logic [63:0] boron_enc_ref(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s, nxt, out;
        logic [79:0] k;
        s   = pt;
        k   = key;
        out = '0;
        for (int r = 1; r <= ROUNDS_DEFAULT; r++) begin
            nxt = lin64(rot64(shuf64(sbox64(s ^ k[63:0]))));
            k   = kupd80(k, r[4:0]);
            if (r == ROUNDS_DEFAULT) out = nxt ^ k[63:0];
            else                     s   = nxt;
        end
        return out;
    endfunction

endpackage

// File: rtl/boron_round_core_if.sv
// Request/result bus between the system load/store logic and the BORON core.
interface boron_round_core_if;
    import boron_pkg::*;

    logic                     start_i;
    logic [DATA_W-1:0]        data_i;
    logic [KEY_W_DEFAULT-1:0] key_i;
    logic                     ready_o;
    logic                     busy_o;
    logic                     done_o;
    logic [DATA_W-1:0]        data_o;

    modport master (output start_i, data_i, key_i, input  ready_o, busy_o, done_o, data_o);
    modport slave  (input  start_i, data_i, key_i, output ready_o, busy_o, done_o, data_o);

endinterface

// File: rtl/boron_round_fn.sv
// One combinational BORON round: AddRoundKey, S-box, byte shuffle, word rotate, XOR mix.
module boron_round_fn
    import boron_pkg::*;
(
    input  logic [DATA_W-1:0] state,
    input  logic [DATA_W-1:0] rk,
    output logic [DATA_W-1:0] nxt
);

    assign nxt = lin64(rot64(shuf64(sbox64(state ^ rk))));

endmodule

// File: rtl/boron_round_core.sv
// Iterative BORON-64/80 encryption core: one round per clock plus final key whitening.
module boron_round_core
    import boron_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT,
    parameter int KEY_W  = KEY_W_DEFAULT
) (
    input logic               clk_i,
    input logic               rst_ni,
    boron_round_core_if.slave bus
);

    fsm_t              fsm_q, fsm_d;
    logic [4:0]        rc_q;
    logic [DATA_W-1:0] state_q, data_q, nxt;
    logic [KEY_W-1:0]  key_q, key_nxt;
    logic              done_q;
    logic              load;
    logic              last;

    boron_round_fn u_round (
        .state (state_q),
        .rk    (key_q[63:0]),
        .nxt   (nxt)
    );

    assign key_nxt = kupd80(key_q, rc_q);
    assign last    = (rc_q == 5'(ROUNDS));

    always_comb begin
        fsm_d = fsm_q;
        load  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.start_i) begin
                    load  = 1'b1;
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                if (last) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) fsm_q <= IDLE;
        else         fsm_q <= fsm_d;
    end

    // The final round writes only the output register, so state_q keeps round 24's value
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                state_q <= bus.data_i;
                key_q   <= bus.key_i;
                rc_q    <= 5'd1;
            end else if (fsm_q == ROUND) begin
                key_q <= key_nxt;
                if (last) begin
                    data_q <= nxt ^ key_nxt[63:0];
                    done_q <= 1'b1;
                end else begin
                    state_q <= nxt;
                    rc_q    <= rc_q + 5'd1;
                end
            end
        end
    end

    assign bus.ready_o = (fsm_q == IDLE);
    assign bus.busy_o  = (fsm_q == ROUND);
    assign bus.done_o  = done_q;
    assign bus.data_o  = data_q;

endmodule

// File: tb/tb_boron_round_core.sv
// Directed self-checking bench for boron_round_core against an independently written cipher model.
module tb_boron_round_core;
    import boron_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    boron_round_core_if bus ();

    boron_round_core dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    function automatic logic [3:0] tb_s(input logic [3:0] x);
        case (x)
            4'h0: return 4'hE;  4'h1: return 4'h4;  4'h2: return 4'hB;  4'h3: return 4'h1;
            4'h4: return 4'h7;  4'h5: return 4'h9;  4'h6: return 4'hC;  4'h7: return 4'hA;
            4'h8: return 4'hD;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'hF;
            4'hC: return 4'h8;  4'hD: return 4'h5;  4'hE: return 4'h3;  default: return 4'h6;
        endcase
    endfunction

    function automatic logic [63:0] tb_round(input logic [63:0] s, input logic [63:0] rk);
        logic [63:0] x, y;
        logic [15:0] w0, w1, w2, w3;
        x = s ^ rk;
        for (int i = 0; i < 16; i++) x[4*i +: 4] = tb_s(x[4*i +: 4]);
        y = {x[23:16], x[31:24], x[7:0], x[55:48], x[15:8], x[63:56], x[39:32], x[47:40]};
        w0 = {y[14:0],  y[15]};
        w1 = {y[27:16], y[31:28]};
        w2 = {y[40:32], y[47:41]};
        w3 = {y[54:48], y[63:55]};
        return {w3 ^ w2 ^ w0, w2 ^ w0, w3 ^ w1, w3 ^ w1 ^ w0};
    endfunction

    function automatic logic [79:0] tb_kupd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r        = {k[66:0], k[79:67]};
        r[3:0]   = tb_s(r[3:0]);
        r[63:59] = r[63:59] ^ rc;
        return r;
    endfunction

    function automatic logic [63:0] tb_enc(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 25; r++) begin
            s = tb_round(s, k[63:0]);
            k = tb_kupd(k, r[4:0]);
        end
        return s ^ k[63:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] pt, input logic [79:0] key);
        bus.start_i = 1'b1;
        bus.data_i  = pt;
        bus.key_i   = key;
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (bus.done_o === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start_i = 1'b1;
        bus.data_i  = 64'hA5A5_5A5A_0F0F_F0F0;
        bus.key_i   = 80'h1234_5678_9ABC_DEF0_2468;
        repeat (3) step();
        checks++; if (bus.ready_o !== 1'b1)   begin errors++; $display("[TB] FAIL reset_ready got %b want 1", bus.ready_o); end
        checks++; if (bus.busy_o  !== 1'b0)   begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.done_o  !== 1'b0)   begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done_o); end
        checks++; if (bus.data_o  !== 64'h0)  begin errors++; $display("[TB] FAIL reset_data got %h want 0", bus.data_o); end
        bus.start_i = 1'b0;
        rst_n       = 1'b1;
        step();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_accept got busy %b want 0", bus.busy_o); end
    endtask

    task automatic test_model();
        logic [63:0] a, b;
        a = boron_enc_ref(64'h0, 80'h0);
        b = tb_enc(64'h0, 80'h0);
        checks++; if (a !== b) begin errors++; $display("[TB] FAIL pkg_ref_zero got %h want %h", a, b); end
        a = boron_enc_ref(64'h0123_4567_89AB_CDEF, 80'hFEDC_BA98_7654_3210_1357);
        b = tb_enc(64'h0123_4567_89AB_CDEF, 80'hFEDC_BA98_7654_3210_1357);
        checks++; if (a !== b) begin errors++; $display("[TB] FAIL pkg_ref_mixed got %h want %h", a, b); end
    endtask

    task automatic test_zero();
        int lat;
        int ready_bad;
        lat       = -1;
        ready_bad = 0;
        issue(64'h0, 80'h0);
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n <= 24 && bus.ready_o !== 1'b0) ready_bad++;
            if (bus.done_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat != 25) begin errors++; $display("[TB] FAIL zero_latency got %0d want 25", lat); end
        checks++; if (ready_bad != 0) begin errors++; $display("[TB] FAIL zero_ready_low got %0d bad cycles want 0", ready_bad); end
        checks++; if (bus.data_o !== tb_enc(64'h0, 80'h0)) begin errors++; $display("[TB] FAIL zero_data got %h want %h", bus.data_o, tb_enc(64'h0, 80'h0)); end
        checks++; if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle_at_done got ready %b busy %b want 1 0", bus.ready_o, bus.busy_o); end
    endtask

    task automatic test_ones();
        int lat;
        int hold_bad;
        logic [63:0] exp;
        exp      = tb_enc(64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
        hold_bad = 0;
        issue(64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
        wait_done(lat);
        checks++; if (lat != 25) begin errors++; $display("[TB] FAIL ones_latency got %0d want 25", lat); end
        checks++; if (bus.data_o !== exp) begin errors++; $display("[TB] FAIL ones_data got %h want %h", bus.data_o, exp); end
        step();
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL ones_done_pulse got %b want 0", bus.done_o); end
        for (int n = 0; n < 9; n++) begin
            if (bus.data_o !== exp) hold_bad++;
            step();
        end
        if (bus.data_o !== exp) hold_bad++;
        checks++; if (hold_bad != 0) begin errors++; $display("[TB] FAIL ones_hold got %0d bad cycles want 0", hold_bad); end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [63:0] exp;
        exp = tb_enc(64'hDEAD_BEEF_0BAD_F00D, 80'h1234_5678_9ABC_DEF0_1357);
        lat = -1;
        issue(64'hDEAD_BEEF_0BAD_F00D, 80'h1234_5678_9ABC_DEF0_1357);
        for (int n = 1; n <= 40; n++) begin
            step();
            if (bus.done_o === 1'b1) begin
                lat = n;
                break;
            end
            bus.start_i = (n == 3 || n == 17);
            bus.data_i  = 64'h1111_2222_3333_4444 + 64'(n);
            bus.key_i   = 80'h9999_8888_7777_6666_5555;
        end
        bus.start_i = 1'b0;
        checks++; if (lat != 25) begin errors++; $display("[TB] FAIL ignore_latency got %0d want 25", lat); end
        checks++; if (bus.data_o !== exp) begin errors++; $display("[TB] FAIL ignore_data got %h want %h", bus.data_o, exp); end
        step();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL ignore_no_queue got busy %b want 0", bus.busy_o); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [63:0] exp_a, exp_b;
        exp_a = tb_enc(64'h1111_1111_1111_1111, 80'hAAAA_AAAA_AAAA_AAAA_AAAA);
        exp_b = tb_enc(64'h0123_4567_89AB_CDEF, 80'h0);
        issue(64'h1111_1111_1111_1111, 80'hAAAA_AAAA_AAAA_AAAA_AAAA);
        wait_done(lat);
        checks++; if (lat != 25) begin errors++; $display("[TB] FAIL b2b_first_latency got %0d want 25", lat); end
        checks++; if (bus.data_o !== exp_a) begin errors++; $display("[TB] FAIL b2b_first_data got %h want %h", bus.data_o, exp_a); end
        issue(64'h0123_4567_89AB_CDEF, 80'h0);
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept got busy %b want 1", bus.busy_o); end
        wait_done(lat);
        checks++; if (lat != 25) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want 25", lat); end
        checks++; if (bus.data_o !== exp_b) begin errors++; $display("[TB] FAIL b2b_second_data got %h want %h", bus.data_o, exp_b); end
    endtask

    task automatic test_abort();
        int lat;
        int done_seen;
        logic [63:0] exp;
        exp       = tb_enc(64'hCAFE_F00D_1234_5678, 80'h0F0F_0F0F_0F0F_0F0F_0F0F);
        done_seen = 0;
        issue(64'h5555_AAAA_5555_AAAA, 80'h3333_3333_3333_3333_3333);
        repeat (11) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_state got ready %b busy %b want 1 0", bus.ready_o, bus.busy_o); end
        checks++; if (bus.data_o !== 64'h0) begin errors++; $display("[TB] FAIL abort_data got %h want 0", bus.data_o); end
        for (int n = 0; n < 30; n++) begin
            if (bus.done_o !== 1'b0) done_seen++;
            step();
        end
        checks++; if (done_seen != 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", done_seen); end
        issue(64'hCAFE_F00D_1234_5678, 80'h0F0F_0F0F_0F0F_0F0F_0F0F);
        wait_done(lat);
        checks++; if (lat != 25) begin errors++; $display("[TB] FAIL abort_restart_latency got %0d want 25", lat); end
        checks++; if (bus.data_o !== exp) begin errors++; $display("[TB] FAIL abort_restart_data got %h want %h", bus.data_o, exp); end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.data_i  = '0;
        bus.key_i   = '0;
        test_reset();
        test_model();
        test_zero();
        test_ones();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
